rs_pulse_driver: RTL and testbench
==================================

Name: rs_pulse_driver

Overview:
Clocked driver for an active-low set/reset latch. It turns single-cycle set or reset requests into clean, glitch-free set0/rst0 pulses. Each pulse has a guaranteed minimum width, the two lines are never low together, and a recovery gap follows every pulse, so the latch never sees too-short, overlapping or oscillation-inducing stimulus. It sits between control logic and any set0/rst0-style latch.

Parameters:
PULSE_CYCLES, 3, cycles set0/rst0 is held low per operation; legal range 1..2^CNT_W-1
GAP_CYCLES, 2, cycles both lines are held high after a pulse before the next request is accepted; legal range 1..2^CNT_W-1
CNT_W, 4, width of the internal cycle counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  operation request
req_op  input  1  0 = set, 1 = reset
ready  output  1  high when a request can be accepted
set0  output  1  active-low set drive to latch, registered
rst0  output  1  active-low reset drive to latch, registered
done  output  1  one-cycle pulse when the recovery gap ends
q_exp  output  1  expected latch state: 1 after set, 0 after reset
q_known  output  1  0 until the first pulse completes, then 1

Behaviour:
- Reset (async assert, sync release): state=IDLE, set0=1, rst0=1, ready=1, done=0, q_exp=0, q_known=0, counter=0.
- States:
  - IDLE: ready=1. On req_valid&&ready, latch req_op, load counter=PULSE_CYCLES-1, go to PULSE. In the same edge, set0 (op 0) or rst0 (op 1) registers low and ready registers 0.
  - PULSE: the selected line stays low. The other line stays high at all times. Counter decrements each cycle. When the counter is 0: drive both lines high at the next edge, update q_exp (set→1, reset→0), set q_known=1, load counter=GAP_CYCLES-1, go to GAP.
  - GAP: both lines high, counter decrements. When the counter is 0: go to IDLE, done=1 for exactly that one cycle, ready=1.
- Latency:
  - Low pulse is exactly PULSE_CYCLES cycles, starting the cycle after acceptance.
  - From acceptance to the next ready=1 is PULSE_CYCLES+GAP_CYCLES+1 cycles.
  - done asserts in the same cycle ready returns to 1.
- Requests while ready=0 are ignored, not queued. req_op is sampled only at acceptance.
- Back-to-back: a request presented in the done cycle is accepted (ready=1 then).
- Invariant: set0 and rst0 are never 0 in the same cycle, including across reset.
- Reset mid-pulse: both lines return high immediately (asynchronous). q_exp/q_known clear. No done is issued.
- Parameter value 0 is illegal. Elaboration must fail via a generate-time check.

Optional Feature:
- Macro: RS_PULSE_DRIVER_SENSE_CHECK_EN.
- When defined, the block adds:
  - input q_sense (the latch's actual q).
  - output err, sticky, reset 0.
- On the last GAP cycle, if q_sense != q_exp, err sets to 1. It clears only on rst.
- When not defined: neither port exists and there is no compare logic.
- Core timing is identical in both builds.

Test Plan:
1. Reset, then req_valid=1, req_op=0 for one cycle (defaults) → set0 low for exactly 3 cycles. Gap of 2 cycles. done=1 with ready=1 at cycle 6 after acceptance. q_exp=1, q_known=1.
2. Set then immediate reset, each issued the cycle ready rises → rst0 low 3 cycles. set0/rst0 never both 0. q_exp=0 after the second pulse.
3. Hold req_valid=1 continuously, alternating req_op every cycle → only requests seen with ready=1 are accepted. Pulses are spaced exactly 6 cycles apart.
4. Assert rst on the 2nd PULSE cycle → set0=1 within the same timestep. q_known=0. No done. ready=1 after release.
5. PULSE_CYCLES=1, GAP_CYCLES=1 → 1-cycle low pulse. ready returns 3 cycles after acceptance.
6. With RS_PULSE_DRIVER_SENSE_CHECK_EN: tie q_sense=0 and issue a set → err=1 at end of gap and stays 1 through later matching ops until rst.

Source files
------------

// File: rtl/rs_pulse_driver.sv
`default_nettype none
// ============================================================================
//  Module   : rs_pulse_driver
//  Brief    : Turns single-cycle set/reset requests into clean, non-overlapping
//             active-low set0/rst0 pulses of fixed width, each followed by a
//             recovery gap, for driving a set0/rst0-style latch.
//             Optional build macro RS_PULSE_DRIVER_SENSE_CHECK_EN adds a
//             q_sense input and a sticky err output that flags a latch whose
//             sensed state disagrees with the expected state at gap end.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_pulse_driver #(
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_op,
`ifdef RS_PULSE_DRIVER_SENSE_CHECK_EN
  input  logic q_sense,
  output logic err,
`endif
  output logic ready,
  output logic set0,
  output logic rst0,
  output logic done,
  output logic q_exp,
  output logic q_known
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks: a zero-length pulse or gap would let
  // the latch see glitches or overlapping stimulus, so refuse to build.
  // --------------------------------------------------------------------------
  generate
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("rs_pulse_driver: CNT_W must be at least 1");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_pulse
      $error("rs_pulse_driver: PULSE_CYCLES out of range 1..2^CNT_W-1");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_gap
      $error("rs_pulse_driver: GAP_CYCLES out of range 1..2^CNT_W-1");
    end
  endgenerate

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Counter reload values; the counter runs N-1 down to 0 for N cycles
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op;        // captured operation: 0 = set, 1 = reset

  logic             accept;    // request taken this cycle
  logic             pulse_end; // last low cycle of the pulse
  logic             gap_end;   // last cycle of the recovery gap
  logic             cnt_zero;

  // Decode the events that drive every register below
  always_comb begin
    cnt_zero  = (cnt == '0);
    accept    = (state == ST_IDLE) && req_valid && ready;
    pulse_end = (state == ST_PULSE) && cnt_zero;
    gap_end   = (state == ST_GAP) && cnt_zero;
  end

  // Sequencer: state, cycle counter, captured op, ready and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op    <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= req_op;
            cnt   <= PULSE_LOAD;
            state <= ST_PULSE;
            ready <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            cnt   <= GAP_LOAD;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Latch drive: only the selected line ever goes low, so set0 and rst0
  // can never be low together; reset forces both high asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set0 <= 1'b1;
      rst0 <= 1'b1;
    end else if (accept) begin
      set0 <= req_op;
      rst0 <= ~req_op;
    end else if (pulse_end || (state != ST_PULSE)) begin
      set0 <= 1'b1;
      rst0 <= 1'b1;
    end
  end

  // Expected latch state, known once the first pulse has completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_exp   <= 1'b0;
      q_known <= 1'b0;
    end else if (pulse_end) begin
      q_exp   <= ~op;
      q_known <= 1'b1;
    end
  end

`ifdef RS_PULSE_DRIVER_SENSE_CHECK_EN
  // Sticky sense mismatch flag, evaluated once per operation at gap end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (gap_end && (q_sense != q_exp)) begin
      err <= 1'b1;
    end
  end
`else
  // No sense input in this build: gap_end is only used by the sense check
  logic unused_gap_end;
  always_comb unused_gap_end = gap_end;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_pulse_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_pulse_driver
//  Brief    : Self-checking bench for rs_pulse_driver. Two instances run side
//             by side (3/2 default timing and 1/1 minimum timing) against an
//             elapsed-time model, plus hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs_pulse_driver;

  logic clk;
  logic rst;
  logic req_valid;
  logic req_op;
  logic q_sense;

  logic a_ready, a_set0, a_rst0, a_done, a_q_exp, a_q_known;
  logic b_ready, b_set0, b_rst0, b_done, b_q_exp, b_q_known;
  logic a_err, b_err;

  int checks = 0;
  int errors = 0;

  rs_pulse_driver dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
`ifdef RS_PULSE_DRIVER_SENSE_CHECK_EN
    .q_sense(q_sense), .err(a_err),
`endif
    .ready(a_ready), .set0(a_set0), .rst0(a_rst0), .done(a_done),
    .q_exp(a_q_exp), .q_known(a_q_known)
  );

  rs_pulse_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
`ifdef RS_PULSE_DRIVER_SENSE_CHECK_EN
    .q_sense(q_sense), .err(b_err),
`endif
    .ready(b_ready), .set0(b_set0), .rst0(b_rst0), .done(b_done),
    .q_exp(b_q_exp), .q_known(b_q_known)
  );

`ifndef RS_PULSE_DRIVER_SENSE_CHECK_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: each instance is described by the number of cycles since its last
  // accepted request (age, 0 = idle). Lines are low for ages 1..P, the new
  // latch state is known from age P+1, and age P+G+1 is the done/ready cycle.
  // ---------------------------------------------------------------------------
  function automatic int pc(input int i);
    return (i == 0) ? 3 : 1;
  endfunction
  function automatic int gc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  int age  [2];
  bit mop  [2];
  bit mq   [2];
  bit mk   [2];
  bit merr [2];

  function automatic bit m_ready(input int i);
    return (age[i] == 0) || (age[i] == pc(i) + gc(i) + 1);
  endfunction

  function automatic logic [7:0] m_outs(input int i);
    bit low;
    low = (age[i] >= 1) && (age[i] <= pc(i));
    return {2'b00, !(low && !mop[i]), !(low && mop[i]), m_ready(i),
            (age[i] == pc(i) + gc(i) + 1), mq[i], mk[i]};
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        age[i] = 0; mop[i] = 0; mq[i] = 0; mk[i] = 0; merr[i] = 0;
      end else begin
        if (age[i] == pc(i) + gc(i) && q_sense != mq[i]) merr[i] = 1;
        if (m_ready(i) && req_valid) begin
          age[i] = 1;
          mop[i] = req_op;
        end else if (age[i] != 0) begin
          age[i] = (age[i] == pc(i) + gc(i) + 1) ? 0 : age[i] + 1;
        end
        if (age[i] == pc(i) + 1) begin
          mq[i] = ~mop[i];
          mk[i] = 1;
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_outputs", {2'b00, a_set0, a_rst0, a_ready, a_done, a_q_exp, a_q_known}, m_outs(0));
      chk("b_outputs", {2'b00, b_set0, b_rst0, b_ready, b_done, b_q_exp, b_q_known}, m_outs(1));
      chk("a_no_overlap", {7'd0, (!a_set0 && !a_rst0)}, 8'd0);
      chk("b_no_overlap", {7'd0, (!b_set0 && !b_rst0)}, 8'd0);
`ifdef RS_PULSE_DRIVER_SENSE_CHECK_EN
      chk("a_err", {7'd0, a_err}, {7'd0, merr[0]});
      chk("b_err", {7'd0, b_err}, {7'd0, merr[1]});
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_a_ready(input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (a_ready) seen = 1;
      else step();
    end
    chk(name, {7'd0, a_ready}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; q_sense = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_set0",    {7'd0, a_set0},    8'd1);
    chk("rst_rst0",    {7'd0, a_rst0},    8'd1);
    chk("rst_ready",   {7'd0, a_ready},   8'd1);
    chk("rst_done",    {7'd0, a_done},    8'd0);
    chk("rst_q_exp",   {7'd0, a_q_exp},   8'd0);
    chk("rst_q_known", {7'd0, a_q_known}, 8'd0);
    chk("rst_err",     {7'd0, a_err},     8'd0);
    rst = 1'b0;

    // Single set: low for cycles 1..3, gap 4..5, done/ready at cycle 6
    step();
    req_valid = 1'b1; req_op = 1'b0;
    step();
    req_valid = 1'b0;
    chk("t1_c1_set0", {7'd0, a_set0}, 8'd0);
    chk("t1_c1_ready", {7'd0, a_ready}, 8'd0);
    chk("t5_c1_set0", {7'd0, b_set0}, 8'd0);
    for (int k = 2; k <= 6; k++) begin
      step();
      if (k == 2) chk("t5_c2_set0", {7'd0, b_set0}, 8'd1);
      if (k == 3) begin
        chk("t1_c3_set0", {7'd0, a_set0}, 8'd0);
        chk("t5_c3_done", {6'd0, b_done, b_ready}, 8'd3);
      end
      if (k == 4) chk("t1_c4_set0", {7'd0, a_set0}, 8'd1);
      if (k == 5) chk("t1_c5_ready", {7'd0, a_ready}, 8'd0);
    end
    chk("t1_c6_done_ready", {6'd0, a_done, a_ready}, 8'd3);
    chk("t1_c6_q", {6'd0, a_q_exp, a_q_known}, 8'd3);

    // Back-to-back reset issued in the done cycle
    req_valid = 1'b1; req_op = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t2_c1_lines", {6'd0, a_set0, a_rst0}, 8'd2);
    repeat (2) step();
    chk("t2_c3_rst0", {7'd0, a_rst0}, 8'd0);
    repeat (3) step();
    chk("t2_c6_done", {7'd0, a_done}, 8'd1);
    chk("t2_c6_q_exp", {7'd0, a_q_exp}, 8'd0);

    // Continuous requests with alternating op: only ready cycles accept
    req_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      req_op = k[0];
      step();
    end
    req_valid = 1'b0;
    wait_a_ready("t3_ready_timeout");

    // Asynchronous reset on the second pulse cycle
    req_valid = 1'b1; req_op = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("t4_pre_set0", {7'd0, a_set0}, 8'd0);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_set0", {6'd0, a_set0, a_rst0}, 8'd3);
    chk("t4_q_known", {6'd0, a_q_exp, a_q_known}, 8'd0);
    chk("t4_ready", {7'd0, a_ready}, 8'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_no_done", {7'd0, a_done}, 8'd0);
    end

`ifdef RS_PULSE_DRIVER_SENSE_CHECK_EN
    // Sense check: latch stuck at 0, set should raise a sticky err
    q_sense = 1'b0;
    req_valid = 1'b1; req_op = 1'b0;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("t6_err_set", {6'd0, a_done, a_err}, 8'd3);
    req_valid = 1'b1; req_op = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("t6_err_sticky", {6'd0, a_done, a_err}, 8'd3);
    rst = 1'b1;
    #1;
    chk("t6_err_clear", {7'd0, a_err}, 8'd0);
    step();
    rst = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
